// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 16-bit CPU datapath.
//   - opcode constants (OPCODE_ADD .. OPCODE_JUMPZ)
//   - alu_op_t: {opcode, f} as a 5-bit operation code
//   - instruction field positions and CMP result bit positions
//   - small helpers: write-back opcode classification, imm8 sign extension
package cpu_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned NUM_REGS  = 8;
  localparam int unsigned REG_SEL_W = 3;

  typedef logic [4:0] alu_op_t;

  // Opcodes (instruction bits [15:12]); 6, 7, 14 and 15 are reserved.
  localparam logic [3:0] OPCODE_ADD   = 4'd0;
  localparam logic [3:0] OPCODE_SUB   = 4'd1;
  localparam logic [3:0] OPCODE_OR    = 4'd2;
  localparam logic [3:0] OPCODE_XOR   = 4'd3;
  localparam logic [3:0] OPCODE_AND   = 4'd4;
  localparam logic [3:0] OPCODE_NOT   = 4'd5;
  localparam logic [3:0] OPCODE_LOAD  = 4'd8;
  localparam logic [3:0] OPCODE_CMP   = 4'd9;
  localparam logic [3:0] OPCODE_SHL   = 4'd10;
  localparam logic [3:0] OPCODE_SHR   = 4'd11;
  localparam logic [3:0] OPCODE_JUMP  = 4'd12;
  localparam logic [3:0] OPCODE_JUMPZ = 4'd13;

  // Instruction field positions.
  localparam int unsigned INST_OP_HI  = 15;
  localparam int unsigned INST_OP_LO  = 12;
  localparam int unsigned INST_RD_HI  = 11;
  localparam int unsigned INST_RD_LO  = 9;
  localparam int unsigned INST_F_BIT  = 8;
  localparam int unsigned INST_RA_HI  = 7;
  localparam int unsigned INST_RA_LO  = 5;
  localparam int unsigned INST_RB_HI  = 4;
  localparam int unsigned INST_RB_LO  = 2;
  localparam int unsigned INST_IMM_HI = 7;
  localparam int unsigned INST_IMM_LO = 0;

  // CMP result bit positions; bits 10:0 are always zero.
  localparam int unsigned CMP_EQ_BIT = 15;
  localparam int unsigned CMP_GT_BIT = 14;
  localparam int unsigned CMP_LT_BIT = 13;
  localparam int unsigned CMP_AZ_BIT = 12;
  localparam int unsigned CMP_BZ_BIT = 11;

  // Only arithmetic/logic, LOAD, CMP and shifts write a destination register.
  function automatic logic is_writeback(input logic [3:0] opcode);
    logic we;
    case (opcode)
      OPCODE_ADD, OPCODE_SUB, OPCODE_OR, OPCODE_XOR, OPCODE_AND,
      OPCODE_NOT, OPCODE_LOAD, OPCODE_CMP, OPCODE_SHL, OPCODE_SHR: we = 1'b1;
      default:                                                      we = 1'b0;
    endcase
    return we;
  endfunction

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: registered ALU (second pipeline edge).
// Ports:
//   clk_i, rst_i (sync, active-high), en_i (hold when low)
//   alu_op_i, data_a_i, data_b_i, data_imm_i, pc_i : operation and operands
//   reg_d_we_i, sel_d_i : write-back request and destination from decode
//   data_result_o, should_branch_o : registered result and branch flag
//   data_write_reg_o, wr_sel_o     : registered write-back request and destination
module cpu_alu import cpu_pkg::*; (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  alu_op_t     alu_op_i,
  input  logic [15:0] data_a_i,
  input  logic [15:0] data_b_i,
  input  logic [15:0] data_imm_i,
  input  logic [15:0] pc_i,
  input  logic        reg_d_we_i,
  input  logic [2:0]  sel_d_i,
  output logic [15:0] data_result_o,
  output logic        should_branch_o,
  output logic        data_write_reg_o,
  output logic [2:0]  wr_sel_o
);

  logic [15:0] data_result_d, data_result_q;
  logic        should_branch_d, should_branch_q;
  logic        data_write_reg_q;
  logic [2:0]  wr_sel_q;
  logic [3:0]  opcode_s;
  logic        f_s;

  assign opcode_s = alu_op_i[4:1];
  assign f_s      = alu_op_i[0];

  // Operation select; reserved opcodes yield zero and no branch.
  always_comb begin
    data_result_d   = 16'h0000;
    should_branch_d = 1'b0;
    case (opcode_s)
      OPCODE_ADD: data_result_d = data_a_i + data_b_i;
      OPCODE_SUB: data_result_d = data_a_i - data_b_i;
      OPCODE_OR:  data_result_d = data_a_i | data_b_i;
      OPCODE_XOR: data_result_d = data_a_i ^ data_b_i;
      OPCODE_AND: data_result_d = data_a_i & data_b_i;
      OPCODE_NOT: data_result_d = ~data_a_i;
      OPCODE_LOAD: begin
        // data_imm_i already holds {8'h00, imm8}; f=0 moves it to the high byte.
        if (f_s) begin
          data_result_d = data_imm_i;
        end else begin
          data_result_d = {data_imm_i[7:0], 8'h00} | {8'h00, data_imm_i[15:8]};
        end
      end
      OPCODE_CMP: begin
        data_result_d[CMP_EQ_BIT] = (data_a_i == data_b_i);
        if (f_s) begin
          data_result_d[CMP_GT_BIT] = ($signed(data_a_i) > $signed(data_b_i));
          data_result_d[CMP_LT_BIT] = ($signed(data_a_i) < $signed(data_b_i));
        end else begin
          data_result_d[CMP_GT_BIT] = (data_a_i > data_b_i);
          data_result_d[CMP_LT_BIT] = (data_a_i < data_b_i);
        end
        data_result_d[CMP_AZ_BIT] = (data_a_i == 16'h0000);
        data_result_d[CMP_BZ_BIT] = (data_b_i == 16'h0000);
      end
      OPCODE_SHL: data_result_d = data_a_i << data_b_i[3:0];
      OPCODE_SHR: data_result_d = data_a_i >> data_b_i[3:0];
      OPCODE_JUMP: begin
        should_branch_d = 1'b1;
        if (f_s) begin
          data_result_d = pc_i + sext8(data_imm_i[7:0]);
        end else begin
          data_result_d = data_a_i;
        end
      end
      OPCODE_JUMPZ: begin
        should_branch_d = (data_a_i == 16'h0000);
        data_result_d   = data_b_i;
      end
      default: begin
        data_result_d   = 16'h0000;
        should_branch_d = 1'b0;
      end
    endcase
  end

  // ALU output register; the destination travels with the result so that
  // write-back stays paired with the instruction that produced it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_result_q    <= 16'h0000;
      should_branch_q  <= 1'b0;
      data_write_reg_q <= 1'b0;
      wr_sel_q         <= 3'd0;
    end else if (en_i) begin
      data_result_q    <= data_result_d;
      should_branch_q  <= should_branch_d;
      data_write_reg_q <= reg_d_we_i;
      wr_sel_q         <= sel_d_i;
    end else begin
      data_result_q    <= data_result_q;
      should_branch_q  <= should_branch_q;
      data_write_reg_q <= data_write_reg_q;
      wr_sel_q         <= wr_sel_q;
    end
  end

  assign data_result_o    = data_result_q;
  assign should_branch_o  = should_branch_q;
  assign data_write_reg_o = data_write_reg_q;
  assign wr_sel_o         = wr_sel_q;

endmodule

// File: rtl/cpu_decode.sv
// cpu_decode: registered instruction decoder (first pipeline edge).
// Ports:
//   clk_i, rst_i (sync, active-high), en_i (hold when low)
//   data_inst_i  : 16-bit instruction word
//   sel_d_o/sel_a_o/sel_b_o : destination / source A / source B selects
//   data_imm_o   : {8'h00, imm8}
//   alu_op_o     : {opcode, f}
//   reg_d_we_o   : instruction writes its destination register
module cpu_decode import cpu_pkg::*; (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [15:0] data_inst_i,
  output logic [2:0]  sel_d_o,
  output logic [2:0]  sel_a_o,
  output logic [2:0]  sel_b_o,
  output logic [15:0] data_imm_o,
  output alu_op_t     alu_op_o,
  output logic        reg_d_we_o
);

  logic [2:0]  sel_d_q, sel_a_q, sel_b_q;
  logic [15:0] data_imm_q;
  alu_op_t     alu_op_q;
  logic        reg_d_we_q;

  // Bits [1:0] of the instruction carry no meaning.
  logic unused_inst_bits_s;
  assign unused_inst_bits_s = ^data_inst_i[1:0];

  // Decode register: split the instruction word into its fields.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_d_q    <= 3'd0;
      sel_a_q    <= 3'd0;
      sel_b_q    <= 3'd0;
      data_imm_q <= 16'h0000;
      alu_op_q   <= 5'd0;
      reg_d_we_q <= 1'b0;
    end else if (en_i) begin
      sel_d_q    <= data_inst_i[INST_RD_HI:INST_RD_LO];
      sel_a_q    <= data_inst_i[INST_RA_HI:INST_RA_LO];
      sel_b_q    <= data_inst_i[INST_RB_HI:INST_RB_LO];
      data_imm_q <= {8'h00, data_inst_i[INST_IMM_HI:INST_IMM_LO]};
      alu_op_q   <= {data_inst_i[INST_OP_HI:INST_OP_LO], data_inst_i[INST_F_BIT]};
      reg_d_we_q <= is_writeback(data_inst_i[INST_OP_HI:INST_OP_LO]);
    end else begin
      sel_d_q    <= sel_d_q;
      sel_a_q    <= sel_a_q;
      sel_b_q    <= sel_b_q;
      data_imm_q <= data_imm_q;
      alu_op_q   <= alu_op_q;
      reg_d_we_q <= reg_d_we_q;
    end
  end

  assign sel_d_o    = sel_d_q;
  assign sel_a_o    = sel_a_q;
  assign sel_b_o    = sel_b_q;
  assign data_imm_o = data_imm_q;
  assign alu_op_o   = alu_op_q;
  assign reg_d_we_o = reg_d_we_q;

endmodule

// File: rtl/cpu_regfile.sv
// cpu_regfile: 8 x 16-bit register file, two combinational read ports and
// one synchronous write port. r0 is an ordinary register.
// Ports:
//   clk_i, rst_i (sync, active-high; clears all registers)
//   we_i, sel_d_i, data_d_i : write port (already qualified by stage enable)
//   sel_a_i/data_a_o, sel_b_i/data_b_o : read ports (old value on same-cycle write)
//   dbg_regs_o : all register contents, only with CPU_DBG_REGS_EN defined
module cpu_regfile import cpu_pkg::*; (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [2:0]       sel_d_i,
  input  logic [15:0]      data_d_i,
  input  logic [2:0]       sel_a_i,
  input  logic [2:0]       sel_b_i,
  output logic [15:0]      data_a_o,
  output logic [15:0]      data_b_o
`ifdef CPU_DBG_REGS_EN
  ,
  output logic [7:0][15:0] dbg_regs_o
`endif
);

  logic [15:0] regs_q [NUM_REGS];

  // Register storage: clear on reset, single write port otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 16'h0000;
      end
    end else if (we_i) begin
      regs_q[sel_d_i] <= data_d_i;
    end else begin
      regs_q[sel_d_i] <= regs_q[sel_d_i];
    end
  end

  // Reads see the registered contents, so a write in the same cycle is not visible yet.
  assign data_a_o = regs_q[sel_a_i];
  assign data_b_o = regs_q[sel_b_i];

`ifdef CPU_DBG_REGS_EN
  // Debug mirror of every register.
  always_comb begin
    dbg_regs_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      dbg_regs_o[i] = regs_q[i];
    end
  end
`endif

endmodule

// File: rtl/cpu_datapath.sv
// cpu_datapath: 16-bit single-issue datapath (decode -> regfile read -> ALU,
// with internal write-back of ALU results).
// Ports:
//   clk, rst (sync, active-high), en (stage enable: hold + no write-back when low)
//   data_inst     : instruction word (held two cycles per instruction)
//   pc            : address of the current instruction (PC-relative jumps)
//   data_result   : registered ALU result / branch target
//   should_branch : registered branch-taken flag
//   dbg_reg0..7   : live register contents, present only when the
//                   CPU_DBG_REGS_EN macro is defined
module cpu_datapath import cpu_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] data_inst,
  input  logic [15:0] pc,
  output logic [15:0] data_result,
  output logic        should_branch
`ifdef CPU_DBG_REGS_EN
  ,
  output logic [15:0] dbg_reg0,
  output logic [15:0] dbg_reg1,
  output logic [15:0] dbg_reg2,
  output logic [15:0] dbg_reg3,
  output logic [15:0] dbg_reg4,
  output logic [15:0] dbg_reg5,
  output logic [15:0] dbg_reg6,
  output logic [15:0] dbg_reg7
`endif
);

  logic [2:0]  sel_d_s, sel_a_s, sel_b_s, wr_sel_s;
  logic [15:0] data_imm_s, data_a_s, data_b_s, data_result_s;
  alu_op_t     alu_op_s;
  logic        reg_d_we_s, data_write_reg_s, should_branch_s, rf_we_s;

  cpu_decode u_decode (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .data_inst_i (data_inst),
    .sel_d_o     (sel_d_s),
    .sel_a_o     (sel_a_s),
    .sel_b_o     (sel_b_s),
    .data_imm_o  (data_imm_s),
    .alu_op_o    (alu_op_s),
    .reg_d_we_o  (reg_d_we_s)
  );

  cpu_alu u_alu (
    .clk_i            (clk),
    .rst_i            (rst),
    .en_i             (en),
    .alu_op_i         (alu_op_s),
    .data_a_i         (data_a_s),
    .data_b_i         (data_b_s),
    .data_imm_i       (data_imm_s),
    .pc_i             (pc),
    .reg_d_we_i       (reg_d_we_s),
    .sel_d_i          (sel_d_s),
    .data_result_o    (data_result_s),
    .should_branch_o  (should_branch_s),
    .data_write_reg_o (data_write_reg_s),
    .wr_sel_o         (wr_sel_s)
  );

  // Write-back only while the stage is enabled.
  assign rf_we_s = data_write_reg_s & en;

`ifdef CPU_DBG_REGS_EN
  logic [7:0][15:0] dbg_regs_s;
`endif

  cpu_regfile u_regfile (
    .clk_i      (clk),
    .rst_i      (rst),
    .we_i       (rf_we_s),
    .sel_d_i    (wr_sel_s),
    .data_d_i   (data_result_s),
    .sel_a_i    (sel_a_s),
    .sel_b_i    (sel_b_s),
    .data_a_o   (data_a_s),
    .data_b_o   (data_b_s)
`ifdef CPU_DBG_REGS_EN
    ,
    .dbg_regs_o (dbg_regs_s)
`endif
  );

  assign data_result   = data_result_s;
  assign should_branch = should_branch_s;

`ifdef CPU_DBG_REGS_EN
  assign dbg_reg0 = dbg_regs_s[0];
  assign dbg_reg1 = dbg_regs_s[1];
  assign dbg_reg2 = dbg_regs_s[2];
  assign dbg_reg3 = dbg_regs_s[3];
  assign dbg_reg4 = dbg_regs_s[4];
  assign dbg_reg5 = dbg_regs_s[5];
  assign dbg_reg6 = dbg_regs_s[6];
  assign dbg_reg7 = dbg_regs_s[7];
`endif

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed self-checking bench for cpu_datapath. Register contents are read
// hierarchically so the bench works with or without CPU_DBG_REGS_EN.
module tb_cpu_datapath;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic [15:0] data_inst = 16'h6000;
  logic [15:0] pc = 16'h0000;
  logic [15:0] data_result;
  logic        should_branch;
`ifdef CPU_DBG_REGS_EN
  logic [15:0] dbg_reg0, dbg_reg1, dbg_reg2, dbg_reg3;
  logic [15:0] dbg_reg4, dbg_reg5, dbg_reg6, dbg_reg7;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_rf [8];

  localparam logic [15:0] NOP = 16'h6000;  // reserved opcode 6: no write, no branch

  cpu_datapath dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .data_inst     (data_inst),
    .pc            (pc),
    .data_result   (data_result),
    .should_branch (should_branch)
`ifdef CPU_DBG_REGS_EN
    ,
    .dbg_reg0 (dbg_reg0), .dbg_reg1 (dbg_reg1), .dbg_reg2 (dbg_reg2), .dbg_reg3 (dbg_reg3),
    .dbg_reg4 (dbg_reg4), .dbg_reg5 (dbg_reg5), .dbg_reg6 (dbg_reg6), .dbg_reg7 (dbg_reg7)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rf_val(input int i);
    logic [2:0] idx;
    idx = i[2:0];
    return dut.u_regfile.regs_q[idx];
  endfunction

  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                        input logic f, input logic [2:0] ra, input logic [2:0] rb);
    return {op, rd, f, ra, rb, 2'b00};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rd,
                                        input logic f, input logic [7:0] imm);
    return {op, rd, f, imm};
  endfunction

  // Present one instruction for two clock edges; outputs then show its result.
  task automatic issue(input logic [15:0] inst, input logic [15:0] p);
    data_inst = inst;
    pc        = p;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    data_inst = NOP;
    repeat (3) @(negedge clk);
    checks++;
    if (data_result !== 16'h0000) begin
      errors++; $display("FAIL reset_result: got %h expected 0000", data_result);
    end
    checks++;
    if (should_branch !== 1'b0) begin
      errors++; $display("FAIL reset_branch: got %b expected 0", should_branch);
    end
    checks++;
    if (dut.u_alu.data_write_reg_q !== 1'b0) begin
      errors++; $display("FAIL reset_write_reg: got %b expected 0", dut.u_alu.data_write_reg_q);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rf_val(i) !== 16'h0000) begin
        errors++; $display("FAIL reset_r%0d: got %h expected 0000", i, rf_val(i));
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_load_or;
    issue(enc_i(4'd8, 3'd0, 1'b0, 8'hFE), 16'h0000);
    checks++;
    if (data_result !== 16'hFE00) begin
      errors++; $display("FAIL load_high: got %h expected FE00", data_result);
    end
    issue(enc_i(4'd8, 3'd1, 1'b1, 8'hED), 16'h0000);
    checks++;
    if (data_result !== 16'h00ED) begin
      errors++; $display("FAIL load_low: got %h expected 00ED", data_result);
    end
    issue(enc_r(4'd2, 3'd2, 1'b0, 3'd0, 3'd1), 16'h0000);
    checks++;
    if (data_result !== 16'hFEED) begin
      errors++; $display("FAIL or_result: got %h expected FEED", data_result);
    end
    issue(NOP, 16'h0000);
    exp_rf = '{16'hFE00, 16'h00ED, 16'hFEED, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rf_val(i) !== exp_rf[i]) begin
        errors++; $display("FAIL load_or_r%0d: got %h expected %h", i, rf_val(i), exp_rf[i]);
      end
    end
  endtask

  task automatic test_add_wrap;
    issue(enc_i(4'd8, 3'd3, 1'b1, 8'h01), 16'h0000);
    issue(enc_i(4'd8, 3'd4, 1'b1, 8'h02), 16'h0000);
    issue(enc_r(4'd0, 3'd3, 1'b0, 3'd3, 3'd4), 16'h0000);
    checks++;
    if (data_result !== 16'h0003) begin
      errors++; $display("FAIL add_result: got %h expected 0003", data_result);
    end
    issue(enc_i(4'd8, 3'd5, 1'b0, 8'hFF), 16'h0000);
    issue(enc_i(4'd8, 3'd6, 1'b1, 8'hFF), 16'h0000);
    issue(enc_r(4'd2, 3'd5, 1'b0, 3'd5, 3'd6), 16'h0000);
    checks++;
    if (data_result !== 16'hFFFF) begin
      errors++; $display("FAIL build_ffff: got %h expected FFFF", data_result);
    end
    issue(enc_r(4'd0, 3'd5, 1'b0, 3'd5, 3'd3), 16'h0000);
    checks++;
    if (data_result !== 16'h0002) begin
      errors++; $display("FAIL add_wrap: got %h expected 0002", data_result);
    end
    issue(NOP, 16'h0000);
    exp_rf = '{16'hFE00, 16'h00ED, 16'hFEED, 16'h0003, 16'h0002, 16'h0002, 16'h00FF, 16'h0000};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rf_val(i) !== exp_rf[i]) begin
        errors++; $display("FAIL add_r%0d: got %h expected %h", i, rf_val(i), exp_rf[i]);
      end
    end
  endtask

  task automatic test_cmp;
    issue(enc_i(4'd8, 3'd0, 1'b0, 8'h80), 16'h0000);
    issue(enc_i(4'd8, 3'd1, 1'b1, 8'h01), 16'h0000);
    issue(enc_r(4'd9, 3'd2, 1'b0, 3'd0, 3'd1), 16'h0000);
    checks++;
    if (data_result !== 16'h4000) begin
      errors++; $display("FAIL cmp_unsigned: got %h expected 4000", data_result);
    end
    issue(enc_r(4'd9, 3'd3, 1'b1, 3'd0, 3'd1), 16'h0000);
    checks++;
    if (data_result !== 16'h2000) begin
      errors++; $display("FAIL cmp_signed: got %h expected 2000", data_result);
    end
    issue(enc_r(4'd9, 3'd4, 1'b0, 3'd1, 3'd1), 16'h0000);
    checks++;
    if (data_result !== 16'h8000) begin
      errors++; $display("FAIL cmp_equal: got %h expected 8000", data_result);
    end
    issue(enc_r(4'd9, 3'd6, 1'b0, 3'd7, 3'd7), 16'h0000);
    checks++;
    if (data_result !== 16'h9800) begin
      errors++; $display("FAIL cmp_zero: got %h expected 9800", data_result);
    end
    issue(NOP, 16'h0000);
    exp_rf = '{16'h8000, 16'h0001, 16'h4000, 16'h2000, 16'h8000, 16'h0002, 16'h9800, 16'h0000};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rf_val(i) !== exp_rf[i]) begin
        errors++; $display("FAIL cmp_r%0d: got %h expected %h", i, rf_val(i), exp_rf[i]);
      end
    end
  endtask

  task automatic test_jump;
    issue(enc_i(4'd12, 3'd7, 1'b1, 8'hFE), 16'h0010);
    checks++;
    if (should_branch !== 1'b1 || data_result !== 16'h000E) begin
      errors++; $display("FAIL jump_rel: got %b/%h expected 1/000E", should_branch, data_result);
    end
    issue(enc_r(4'd12, 3'd0, 1'b0, 3'd2, 3'd0), 16'h0020);
    checks++;
    if (should_branch !== 1'b1 || data_result !== 16'h4000) begin
      errors++; $display("FAIL jump_abs: got %b/%h expected 1/4000", should_branch, data_result);
    end
    issue(enc_r(4'd13, 3'd0, 1'b0, 3'd7, 3'd1), 16'h0000);
    checks++;
    if (should_branch !== 1'b1 || data_result !== 16'h0001) begin
      errors++; $display("FAIL jumpz_taken: got %b/%h expected 1/0001", should_branch, data_result);
    end
    issue(enc_r(4'd13, 3'd0, 1'b0, 3'd1, 3'd2), 16'h0000);
    checks++;
    if (should_branch !== 1'b0 || data_result !== 16'h4000) begin
      errors++; $display("FAIL jumpz_not_taken: got %b/%h expected 0/4000", should_branch, data_result);
    end
    issue(NOP, 16'h0000);
    checks++;
    if (should_branch !== 1'b0 || data_result !== 16'h0000) begin
      errors++; $display("FAIL reserved_op: got %b/%h expected 0/0000", should_branch, data_result);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rf_val(i) !== exp_rf[i]) begin
        errors++; $display("FAIL jump_r%0d: got %h expected %h", i, rf_val(i), exp_rf[i]);
      end
    end
  endtask

  task automatic test_alu_misc;
    issue(enc_r(4'd10, 3'd6, 1'b0, 3'd6, 3'd1), 16'h0000);
    checks++;
    if (data_result !== 16'h3000) begin
      errors++; $display("FAIL shl: got %h expected 3000", data_result);
    end
    issue(enc_r(4'd11, 3'd7, 1'b0, 3'd0, 3'd5), 16'h0000);
    checks++;
    if (data_result !== 16'h2000) begin
      errors++; $display("FAIL shr: got %h expected 2000", data_result);
    end
    issue(enc_r(4'd1, 3'd5, 1'b0, 3'd1, 3'd2), 16'h0000);
    checks++;
    if (data_result !== 16'hC001) begin
      errors++; $display("FAIL sub: got %h expected C001", data_result);
    end
    issue(enc_r(4'd3, 3'd4, 1'b0, 3'd0, 3'd2), 16'h0000);
    checks++;
    if (data_result !== 16'hC000) begin
      errors++; $display("FAIL xor: got %h expected C000", data_result);
    end
    issue(enc_r(4'd5, 3'd3, 1'b0, 3'd1, 3'd0), 16'h0000);
    checks++;
    if (data_result !== 16'hFFFE) begin
      errors++; $display("FAIL not: got %h expected FFFE", data_result);
    end
    issue(enc_r(4'd4, 3'd2, 1'b0, 3'd2, 3'd4), 16'h0000);
    checks++;
    if (data_result !== 16'h4000) begin
      errors++; $display("FAIL and: got %h expected 4000", data_result);
    end
    issue(enc_r(4'd14, 3'd0, 1'b1, 3'd1, 3'd2), 16'h0000);
    checks++;
    if (data_result !== 16'h0000 || should_branch !== 1'b0) begin
      errors++; $display("FAIL reserved_14: got %b/%h expected 0/0000", should_branch, data_result);
    end
    issue(NOP, 16'h0000);
    exp_rf = '{16'h8000, 16'h0001, 16'h4000, 16'hFFFE, 16'hC000, 16'hC001, 16'h3000, 16'h2000};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rf_val(i) !== exp_rf[i]) begin
        errors++; $display("FAIL misc_r%0d: got %h expected %h", i, rf_val(i), exp_rf[i]);
      end
    end
  endtask

  task automatic test_enable;
    en = 1'b0;
    data_inst = enc_i(4'd8, 3'd0, 1'b1, 8'h55);
    repeat (4) @(negedge clk);
    checks++;
    if (data_result !== 16'h0000) begin
      errors++; $display("FAIL en_hold_result: got %h expected 0000", data_result);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rf_val(i) !== exp_rf[i]) begin
        errors++; $display("FAIL en_hold_r%0d: got %h expected %h", i, rf_val(i), exp_rf[i]);
      end
    end
    data_inst = NOP;
    en = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rf_val(i) !== exp_rf[i]) begin
        errors++; $display("FAIL en_resume_r%0d: got %h expected %h", i, rf_val(i), exp_rf[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    data_inst = enc_i(4'd8, 3'd2, 1'b1, 8'h77);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (data_result !== 16'h0000 || should_branch !== 1'b0) begin
      errors++; $display("FAIL mid_reset_out: got %b/%h expected 0/0000", should_branch, data_result);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rf_val(i) !== 16'h0000) begin
        errors++; $display("FAIL mid_reset_r%0d: got %h expected 0000", i, rf_val(i));
      end
    end
    rst = 1'b0;
    data_inst = NOP;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rf_val(i) !== 16'h0000) begin
        errors++; $display("FAIL discard_r%0d: got %h expected 0000", i, rf_val(i));
      end
    end
    issue(enc_i(4'd8, 3'd7, 1'b1, 8'h12), 16'h0000);
    issue(NOP, 16'h0000);
    checks++;
    if (rf_val(7) !== 16'h0012) begin
      errors++; $display("FAIL post_reset_load: got %h expected 0012", rf_val(7));
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_load_or();
    test_add_wrap();
    test_cmp();
    test_jump();
    test_alu_misc();
    test_enable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_datapath.md
# cpu_datapath

16-bit single-issue CPU datapath: a registered instruction decoder, an 8×16-bit register file and a registered ALU. Sits between instruction fetch/control (which supplies the instruction word, `pc` and `en`) and the branch/PC logic (which consumes `should_branch` and `data_result`). Results are written back to the register file internally.

## Interface
- No parameters; data width 16, 8 registers, 16-bit instruction word.
- `clk` in 1: system clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: stage enable; when low, all registers hold and no write-back occurs.
- `data_inst` in 16: instruction word.
- `pc` in 16: address of the current instruction, used for PC-relative jumps.
- `data_result` out 16: registered ALU result (write-back value or branch target).
- `should_branch` out 1: registered branch-taken flag, aligned with `data_result`.
- `dbg_reg0`..`dbg_reg7` out 16 each: live register contents (see Configuration).

## Operation
- Instruction format: [15:12] opcode, [11:9] rd, [8] f, [7:5] ra, [4:2] rb, [1:0] unused; imm8 = [7:0].
- Decode produces `sel_d`=rd, `sel_a`=ra, `sel_b`=rb, `data_imm`={8'h00,imm8}, `alu_op`={opcode,f} (5 bits), `reg_d_we`=1 for write-back opcodes only.
- Register file: 2 combinational read ports (a, b), 1 synchronous write port (d); r0 is an ordinary register.
- Opcodes and ALU result (all arithmetic 16-bit, wrap-around, no carry out):
  - 0 ADD a+b; 1 SUB a−b; 2 OR a|b; 3 XOR a^b; 4 AND a&b; 5 NOT ~a. All write rd.
  - 8 LOAD: f=0 → {imm8,8'h00} (load high); f=1 → {8'h00,imm8} (load low). Writes rd; other byte is zeroed.
  - 9 CMP: bit15 a==b, bit14 a>b, bit13 a<b (f=0 unsigned, f=1 signed), bit12 a==0, bit11 b==0, bits 10:0 zero. Writes rd.
  - 10 SHL a<<b[3:0]; 11 SHR a>>b[3:0] (logical). Write rd.
  - 12 JUMP: should_branch=1; f=0 target=a, f=1 target=pc+sign-extended imm8. No write.
  - 13 JUMPZ: should_branch=(a==0); target=b. No write.
  - 6, 7, 14, 15: reserved; result 0, should_branch 0, no write.
- Write-back: `data_result` is written into register `sel_d` when ALU-stage `data_write_reg` (the registered copy of `reg_d_we`) is 1 and `en`=1.

## Timing
- Edge E0: decode register captures `data_inst`. Register reads are combinational from the decoded selects.
- Edge E1: ALU registers `data_result`, `should_branch`, `data_write_reg`.
- Edge E2: register file write.
- Issue rule: each instruction is held for 2 cycles. Dependent instructions issued at 2-cycle spacing read correct values with no forwarding. Re-executing a held instruction is idempotent.
- Reset: decode outputs, `data_result`, `should_branch`, `data_write_reg` and all 8 registers become 0. Reset has priority over `en`. Reset mid-instruction discards it.
- A simultaneous read and write of the same register returns the old value.

## Configuration
- `CPU_DBG_REGS_EN` defined: `dbg_reg0`..`dbg_reg7` ports exist and mirror the registers combinationally.
- Not defined: the debug ports are omitted; behaviour is otherwise identical.

## Structure
- Shared package `cpu_pkg`: opcode constants (OPCODE_ADD … OPCODE_JUMPZ), CMP bit positions, the `alu_op_t` 5-bit typedef, and instruction field positions.
- Sub-modules: `cpu_decode`, `cpu_alu`, `cpu_regfile` (8×16); the top wires them with internal write-back.

## Test plan
- LOAD f=0 r0,0xFE; LOAD f=1 r1,0xED; OR r2,r0,r1 at 2-cycle spacing → r0=0xFE00, r1=0x00ED, r2=0xFEED.
- LOAD r3=1, r4=2; ADD r3,r3,r4 → r3=3. Set r5=0xFFFF, ADD r5,r5,r3 → r5=0x0002 (wrap).
- CMP with a=0x8000, b=0x0001: f=0 → bit14=1 (unsigned >); f=1 → bit13=1 (signed <).
- JUMP f=1 imm8=0xFE, pc=0x0010 → should_branch=1, data_result=0x000E; no register changes.
- `en`=0 for 4 cycles with a LOAD applied → no register changes. Assert `rst` mid-sequence → all registers and outputs read 0 on the next edge.
- With `CPU_DBG_REGS_EN` undefined, the top elaborates without the debug ports and the first scenario passes via a hierarchical check.
